// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t : controller FSM states (RUN, MEM_WAIT, TRAP)
//   REG_X0  : architectural zero register address (never a real dependency)
//   WAIT_W  : width of the memory-wait counter (covers MAX_WAIT up to 255)
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int         WAIT_W = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives hazard inputs, receives enables/flushes
//   slave  : controller side, the reverse
// Signals:
//   idRs1Addr/idRs2Addr/idUsesRs1/idUsesRs2 : ID-stage source operands
//   exRdAddr/exIsLoad/exBranchTaken         : EX-stage destination and control
//   memReq/memReady                         : data-memory handshake in MEM
//   pcWe, weFD, weDE, weEM, weMW            : PC / bank write-enables
//   flushFD, flushDE, flushMW               : bubble insertion strobes
//   memTimeout, stallCycles                 : sticky timeout flag, stall counter
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic [REG_AW-1:0] idRs1Addr;
  logic [REG_AW-1:0] idRs2Addr;
  logic              idUsesRs1;
  logic              idUsesRs2;
  logic [REG_AW-1:0] exRdAddr;
  logic              exIsLoad;
  logic              exBranchTaken;
  logic              memReq;
  logic              memReady;
  logic              pcWe;
  logic              weFD;
  logic              weDE;
  logic              weEM;
  logic              weMW;
  logic              flushFD;
  logic              flushDE;
  logic              flushMW;
  logic              memTimeout;
  logic [CNT_W-1:0]  stallCycles;

  modport master (
    output idRs1Addr, idRs2Addr, idUsesRs1, idUsesRs2,
    output exRdAddr, exIsLoad, exBranchTaken, memReq, memReady,
    input  pcWe, weFD, weDE, weEM, weMW, flushFD, flushDE, flushMW,
    input  memTimeout, stallCycles
  );

  modport slave (
    input  idRs1Addr, idRs2Addr, idUsesRs1, idUsesRs2,
    input  exRdAddr, exIsLoad, exBranchTaken, memReq, memReady,
    output pcWe, weFD, weDE, weEM, weMW, flushFD, flushDE, flushMW,
    output memTimeout, stallCycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard comparator.
//   idRs1Addr/idRs2Addr, idUsesRs1/idUsesRs2 : operands read by the ID instruction
//   exRdAddr, exIsLoad                       : destination of the instruction in EX
//   loadUse                                  : ID needs a value the EX load has not produced yet
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idRs1Addr,
  input  logic [REG_AW-1:0] idRs2Addr,
  input  logic              idUsesRs1,
  input  logic              idUsesRs2,
  input  logic [REG_AW-1:0] exRdAddr,
  input  logic              exIsLoad,
  output logic              loadUse
);

  logic rd_real;
  logic hit_rs1;
  logic hit_rs2;

  // Writes to x0 are discarded, so they never create a dependency.
  assign rd_real = (exRdAddr != REG_AW'(REG_X0));
  assign hit_rs1 = idUsesRs1 & (idRs1Addr == exRdAddr);
  assign hit_rs2 = idUsesRs2 & (idRs2Addr == exRdAddr);
  assign loadUse = exIsLoad & rd_real & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: sequences the PC and the IF/ID, ID/EX, EX/MEM,
// MEM/WB register banks for load-use stalls, taken-branch redirects and
// multi-cycle data-memory waits; traps on a memory timeout and counts stalls.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : pipeline_hazard_ctrl_if slave (hazard inputs, enables, flushes,
//           memTimeout, stallCycles)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic [CNT_W-1:0]  stall_cnt;
  logic              timeout;
  logic              load_use;
  logic              mem_wait;
  logic              freeze;
  logic              pc_we, we_fd, we_de, we_em, we_mw;
  logic              fl_fd, fl_de, fl_mw;

  pipeline_hazard_ctrl_hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .idRs1Addr (bus.idRs1Addr),
    .idRs2Addr (bus.idRs2Addr),
    .idUsesRs1 (bus.idUsesRs1),
    .idUsesRs2 (bus.idUsesRs2),
    .exRdAddr  (bus.exRdAddr),
    .exIsLoad  (bus.exIsLoad),
    .loadUse   (load_use)
  );

  assign mem_wait = bus.memReq & ~bus.memReady;
  // Once waiting, only memReady ends the freeze; memReq is not re-examined.
  assign freeze = ((state == RUN) & mem_wait) | ((state == MEM_WAIT) & ~bus.memReady);

  // Next-state and wait counter
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_wait) begin
          // The entry cycle is the first wait cycle.
          wait_cnt_nx = WAIT_W'(1);
          state_nx    = (wait_cnt_nx >= MAX_WAIT_C) ? TRAP : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.memReady) begin
          wait_cnt_nx = '0;
          state_nx    = RUN;
        end else begin
          wait_cnt_nx = wait_cnt + WAIT_W'(1);
          if (wait_cnt_nx >= MAX_WAIT_C) state_nx = TRAP;
        end
      end
      TRAP:    state_nx = TRAP;
      default: state_nx = RUN;
    endcase
  end

  // Output decode: reset > TRAP > freeze > branch > load-use > run
  always_comb begin
    pc_we = 1'b0;
    we_fd = 1'b0;
    we_de = 1'b0;
    we_em = 1'b0;
    we_mw = 1'b0;
    fl_fd = 1'b0;
    fl_de = 1'b0;
    fl_mw = 1'b0;
    if (reset) begin
      fl_fd = 1'b1;
      fl_de = 1'b1;
      fl_mw = 1'b1;
    end else if (state == TRAP) begin
      fl_mw = 1'b1;
    end else if (freeze) begin
      // MEM/WB keeps advancing so a bubble drains behind the stalled access.
      we_mw = 1'b1;
      fl_mw = 1'b1;
    end else if (bus.exBranchTaken) begin
      {pc_we, we_fd, we_de, we_em, we_mw} = 5'b11111;
      fl_fd = 1'b1;
      fl_de = 1'b1;
    end else if (load_use) begin
      {we_de, we_em, we_mw} = 3'b111;
      fl_de = 1'b1;
    end else begin
      {pc_we, we_fd, we_de, we_em, we_mw} = 5'b11111;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (state_nx == TRAP) timeout <= 1'b1;
      if (!pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.pcWe        = pc_we;
  assign bus.weFD        = we_fd;
  assign bus.weDE        = we_de;
  assign bus.weEM        = we_em;
  assign bus.weMW        = we_mw;
  assign bus.flushFD     = fl_fd;
  assign bus.flushDE     = fl_de;
  assign bus.flushMW     = fl_mw;
  assign bus.memTimeout  = timeout;
  assign bus.stallCycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  // {pcWe, weFD, weDE, weEM, weMW, flushFD, flushDE, flushMW}
  localparam logic [7:0] P_RST  = 8'b00000_111;
  localparam logic [7:0] P_RUN  = 8'b11111_000;
  localparam logic [7:0] P_LU   = 8'b00111_010;
  localparam logic [7:0] P_BR   = 8'b11111_110;
  localparam logic [7:0] P_FRZ  = 8'b00001_001;
  localparam logic [7:0] P_TRAP = 8'b00000_001;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MAX_WAIT(15), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] outs;
  assign outs = {bus.pcWe, bus.weFD, bus.weDE, bus.weEM, bus.weMW,
                 bus.flushFD, bus.flushDE, bus.flushMW};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.idRs1Addr = '0; bus.idRs2Addr = '0;
    bus.idUsesRs1 = 1'b0; bus.idUsesRs2 = 1'b0;
    bus.exRdAddr = '0; bus.exIsLoad = 1'b0; bus.exBranchTaken = 1'b0;
    bus.memReq = 1'b0; bus.memReady = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    bus.exIsLoad = 1'b1; bus.exRdAddr = r;
    bus.idUsesRs1 = 1'b1; bus.idRs1Addr = r;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    n_chk++;
    if (outs !== P_RST) $display("FAIL reset_outs: got %b expected %b", outs, P_RST);
    else n_pass++;
    step();
    reset = 1'b0;
    #2;
    n_chk++;
    if (bus.stallCycles !== 4'd0 || bus.memTimeout !== 1'b0)
      $display("FAIL reset_regs: got cnt=%0d to=%b expected cnt=0 to=0", bus.stallCycles, bus.memTimeout);
    else n_pass++;
    n_chk++;
    if (outs !== P_RUN) $display("FAIL reset_run: got %b expected %b", outs, P_RUN);
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #2;
    n_chk++;
    if (outs !== P_LU) $display("FAIL lu_stall: got %b expected %b", outs, P_LU);
    else n_pass++;
    step();
    idle_inputs();
    #2;
    n_chk++;
    if (outs !== P_RUN) $display("FAIL lu_release: got %b expected %b", outs, P_RUN);
    else n_pass++;
    n_chk++;
    if (bus.stallCycles !== 4'd1) $display("FAIL lu_count: got %0d expected 1", bus.stallCycles);
    else n_pass++;
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_load_use(5'd0);
    #2;
    n_chk++;
    if (outs !== P_RUN) $display("FAIL lu_x0: got %b expected %b", outs, P_RUN);
    else n_pass++;
    idle_inputs();
    bus.exIsLoad = 1'b1; bus.exRdAddr = 5'd5;
    bus.idRs2Addr = 5'd5; bus.idUsesRs2 = 1'b0;
    bus.idRs1Addr = 5'd3; bus.idUsesRs1 = 1'b1;
    #2;
    n_chk++;
    if (outs !== P_RUN) $display("FAIL lu_rs2_unused: got %b expected %b", outs, P_RUN);
    else n_pass++;
    bus.idUsesRs2 = 1'b1;
    #2;
    n_chk++;
    if (outs !== P_LU) $display("FAIL lu_rs2_used: got %b expected %b", outs, P_LU);
    else n_pass++;
    idle_inputs();
    step();
    n_chk++;
    if (bus.stallCycles !== 4'd0) $display("FAIL no_hazard_count: got %0d expected 0", bus.stallCycles);
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.memReq = 1'b1; bus.memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_chk++;
      if (outs !== P_FRZ) $display("FAIL mem_freeze%0d: got %b expected %b", i, outs, P_FRZ);
      else n_pass++;
      step();
    end
    bus.memReady = 1'b1;
    #2;
    n_chk++;
    if (outs !== P_RUN) $display("FAIL mem_release: got %b expected %b", outs, P_RUN);
    else n_pass++;
    step();
    idle_inputs();
    #2;
    n_chk++;
    if (bus.stallCycles !== 4'd3) $display("FAIL mem_count: got %0d expected 3", bus.stallCycles);
    else n_pass++;
    n_chk++;
    if (outs !== P_RUN || bus.memTimeout !== 1'b0)
      $display("FAIL mem_after: got %b to=%b expected %b to=0", outs, bus.memTimeout, P_RUN);
    else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    set_load_use(5'd5);
    bus.exBranchTaken = 1'b1;
    #2;
    n_chk++;
    if (outs !== P_BR) $display("FAIL br_over_lu: got %b expected %b", outs, P_BR);
    else n_pass++;
    step();
    idle_inputs();
    bus.exBranchTaken = 1'b1; bus.memReq = 1'b1; bus.memReady = 1'b0;
    #2;
    n_chk++;
    if (outs !== P_FRZ) $display("FAIL br_with_wait: got %b expected %b", outs, P_FRZ);
    else n_pass++;
    step();
    bus.memReady = 1'b1;
    #2;
    n_chk++;
    if (outs !== P_BR) $display("FAIL br_on_ready: got %b expected %b", outs, P_BR);
    else n_pass++;
    step();
    idle_inputs();
    #2;
    n_chk++;
    if (bus.stallCycles !== 4'd1 || outs !== P_RUN)
      $display("FAIL br_after: got cnt=%0d %b expected cnt=1 %b", bus.stallCycles, outs, P_RUN);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.memReq = 1'b1; bus.memReady = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #2;
      n_chk++;
      if (outs !== P_FRZ) $display("FAIL to_freeze%0d: got %b expected %b", i, outs, P_FRZ);
      else n_pass++;
      if (i == 14) begin
        n_chk++;
        if (bus.memTimeout !== 1'b0) $display("FAIL to_early: got %b expected 0", bus.memTimeout);
        else n_pass++;
      end
      step();
    end
    #2;
    n_chk++;
    if (outs !== P_TRAP || bus.memTimeout !== 1'b1)
      $display("FAIL to_trap: got %b to=%b expected %b to=1", outs, bus.memTimeout, P_TRAP);
    else n_pass++;
    bus.memReady = 1'b1;
    step();
    n_chk++;
    if (outs !== P_TRAP || bus.memTimeout !== 1'b1)
      $display("FAIL to_hold: got %b to=%b expected %b to=1", outs, bus.memTimeout, P_TRAP);
    else n_pass++;
    n_chk++;
    if (bus.stallCycles !== 4'hF) $display("FAIL to_count: got %0d expected 15", bus.stallCycles);
    else n_pass++;
    reset = 1'b1;
    #2;
    n_chk++;
    if (outs !== P_RST) $display("FAIL to_reset_outs: got %b expected %b", outs, P_RST);
    else n_pass++;
    step();
    reset = 1'b0;
    idle_inputs();
    #2;
    n_chk++;
    if (outs !== P_RUN || bus.memTimeout !== 1'b0 || bus.stallCycles !== 4'd0)
      $display("FAIL to_cleared: got %b to=%b cnt=%0d expected %b to=0 cnt=0",
               outs, bus.memTimeout, bus.stallCycles, P_RUN);
    else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    set_load_use(5'd7);
    for (int i = 0; i < 14; i++) step();
    n_chk++;
    if (bus.stallCycles !== 4'd14) $display("FAIL sat_14: got %0d expected 14", bus.stallCycles);
    else n_pass++;
    step();
    n_chk++;
    if (bus.stallCycles !== 4'hF) $display("FAIL sat_15: got %0d expected 15", bus.stallCycles);
    else n_pass++;
    for (int i = 0; i < 4; i++) step();
    n_chk++;
    if (bus.stallCycles !== 4'hF) $display("FAIL sat_19: got %0d expected 15", bus.stallCycles);
    else n_pass++;
    idle_inputs();
    step();
    n_chk++;
    if (bus.stallCycles !== 4'hF || outs !== P_RUN)
      $display("FAIL sat_after: got cnt=%0d %b expected cnt=15 %b", bus.stallCycles, outs, P_RUN);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_branch();
    test_timeout();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
